// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces sync, blanking, raster position and cell coordinates for the
// maze renderer. Cell size is sampled once per frame so the grid cannot
// change while a frame is being drawn.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_En,
  input  logic [CW-1:0] i_PixelSize,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_HBlank,
  output logic          o_VBlank,
  output logic          o_Blank,
  output logic [9:0]    o_HPos,
  output logic [9:0]    o_VPos,
  output logic [CW-1:0] o_XPos,
  output logic [CW-1:0] o_YPos,
  output logic          o_NewLine,
  output logic          o_NewFrame,
  output logic          o_FrameDone
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_ACT_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CELL_ONE  = CW'(1);

  logic [9:0]    hCntReg, hCntNext;
  logic [9:0]    vCntReg, vCntNext;
  logic [CW-1:0] xSubReg, xSubNext;
  logic [CW-1:0] ySubReg, ySubNext;
  logic [CW-1:0] xCellReg, xCellNext;
  logic [CW-1:0] yCellReg, yCellNext;
  logic [CW-1:0] rSizeReg, rSizeNext;

  logic lineEnd;
  logic frameEnd;

  assign lineEnd  = (hCntReg == H_LAST);
  assign frameEnd = lineEnd && (vCntReg == V_LAST);

  // Next-state logic: raster counters, cell sub-counters and size latch.
  always_comb begin
    hCntNext  = hCntReg;
    vCntNext  = vCntReg;
    xSubNext  = xSubReg;
    ySubNext  = ySubReg;
    xCellNext = xCellReg;
    yCellNext = yCellReg;
    rSizeNext = rSizeReg;

    if (i_En) begin
      hCntNext = lineEnd ? 10'd0 : hCntReg + 10'd1;
      if (lineEnd) begin
        vCntNext = frameEnd ? 10'd0 : vCntReg + 10'd1;
      end

      // Columns advance only across visible pixels; anywhere in the
      // horizontal blank (including the line-end step) they sit at zero
      // so the next line starts at column 0 with a fresh sub-count.
      if (hCntReg < H_ACT) begin
        if (xSubReg == rSizeReg) begin
          xSubNext  = '0;
          xCellNext = xCellReg + CELL_ONE;
        end else begin
          xSubNext  = xSubReg + CELL_ONE;
        end
      end else begin
        xSubNext  = '0;
        xCellNext = '0;
      end

      // Rows advance once per visible line; from the last visible line
      // onward they are parked at zero for the whole vertical blank.
      if (lineEnd) begin
        if (vCntReg < V_ACT_LAST) begin
          if (ySubReg == rSizeReg) begin
            ySubNext  = '0;
            yCellNext = yCellReg + CELL_ONE;
          end else begin
            ySubNext  = ySubReg + CELL_ONE;
          end
        end else begin
          ySubNext  = '0;
          yCellNext = '0;
        end
      end

      if (frameEnd) begin
        rSizeNext = i_PixelSize;
      end
    end
  end

  // State register; reset clears the raster and samples the cell size.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hCntReg  <= '0;
      vCntReg  <= '0;
      xSubReg  <= '0;
      ySubReg  <= '0;
      xCellReg <= '0;
      yCellReg <= '0;
      rSizeReg <= i_PixelSize;
    end else begin
      hCntReg  <= hCntNext;
      vCntReg  <= vCntNext;
      xSubReg  <= xSubNext;
      ySubReg  <= ySubNext;
      xCellReg <= xCellNext;
      yCellReg <= yCellNext;
      rSizeReg <= rSizeNext;
    end
  end

  assign o_HBlank    = (hCntReg >= H_ACT);
  assign o_VBlank    = (vCntReg >= V_ACT);
  assign o_Blank     = o_HBlank | o_VBlank;
  assign o_HSync     = ((hCntReg >= H_SYNC_START) && (hCntReg < H_SYNC_END)) ? H_POL : ~H_POL;
  assign o_VSync     = ((vCntReg >= V_SYNC_START) && (vCntReg < V_SYNC_END)) ? V_POL : ~V_POL;
  assign o_HPos      = hCntReg;
  assign o_VPos      = vCntReg;
  assign o_XPos      = xCellReg;
  assign o_YPos      = yCellReg;
  assign o_NewLine   = (hCntReg == 10'd0);
  assign o_NewFrame  = (hCntReg == 10'd0) && (vCntReg == 10'd0);
  assign o_FrameDone = (hCntReg == H_ACT_LAST) && (vCntReg == V_ACT_LAST);

endmodule
